noc_injector: RTL and testbench
===============================

Name: noc_injector

Overview:
- Local-to-mesh packet injector. It sits directly upstream of a mesh node input port and drives that port's flit/enable signals while honouring its ack.
- It accepts a packet descriptor (destination and length) and a stream of payload words into an internal FIFO.
- It serialises each packet as one HEADER flit, zero or more BODY flits and one TAIL flit.

Parameters:
- DEPTH, 8, payload FIFO entries; must be a power of 2, at least 2.
- LEN_W, 4, width of the descriptor length field; maximum packet length is 2**LEN_W-1 data words.
- PAYLOAD_W, $bits(flit_t.payload), payload word width; fixed by noc_types, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- desc_valid_i  in  1  descriptor offered.
- desc_ready_o  out  1  descriptor accepted on the rising edge where valid&&ready.
- desc_dst_i  in  $bits(addr_t)  destination node address.
- desc_len_i  in  LEN_W  number of data words in the packet (0 allowed).
- wr_valid_i  in  1  payload word offered.
- wr_ready_o  out  1  FIFO not full.
- wr_data_i  in  PAYLOAD_W  payload word.
- flit_o  out  $bits(flit_t)  flit toward node input port.
- enable_o  out  1  flit_o is valid.
- ack_i  in  1  node grant/backpressure; a flit transfers on a rising edge where enable_o&&ack_i.
- busy_o  out  1  a packet is in flight (state != IDLE).
- pkt_count_o  out  16  count of completed packets (TAIL transferred); wraps 0xFFFF->0.

Behaviour:
- Reset values (async, immediate):
  - state=IDLE, FIFO empty, remaining=0, pkt_count_o=0.
  - enable_o=0, flit_o={BODY, payload 0}, desc_ready_o=1, wr_ready_o=1, busy_o=0.
- Idle flit rule: whenever enable_o=0, flit_o.flit_type=BODY and payload=0.
  - Never present HEADER or TAIL with enable low; the downstream node frees its route on a TAIL type alone.
- FIFO:
  - Registered, no bypass. A word pushed at edge N is poppable from cycle N+1.
  - Push when wr_valid_i&&wr_ready_o; wr_ready_o=!full.
  - Push and pop in the same edge are both legal when neither full nor empty. Count is unchanged and pointers wrap modulo DEPTH.
  - Writes are accepted in any FSM state, including before the descriptor arrives.
- FSM states are IDLE, HDR and DATA; transitions are evaluated on the rising edge.
- IDLE:
  - desc_ready_o=1.
  - On accept: latch dst and len (remaining<=desc_len_i), go to HDR.
  - The header appears in the cycle after the accept edge.
- HDR:
  - enable_o=1; flit_type=HEADER; payload is flit_hdr_t with dst_addr=latched dst and all other fields 0.
  - Hold the flit unchanged until ack_i is high at an edge, then go to DATA.
  - ack_i low holds indefinitely (route not granted).
- DATA with remaining=0 (len-0 packet):
  - enable_o=1, flit_type=TAIL, payload=0.
  - On transfer: go to IDLE, pkt_count_o+1.
- DATA with remaining>0:
  - enable_o=!fifo_empty; payload=FIFO head.
  - flit_type=TAIL if remaining==1, else BODY.
  - On transfer: pop, remaining-1.
  - If the transferred flit was TAIL: go to IDLE, pkt_count_o+1.
  - FIFO empty inserts a bubble (enable low, idle flit rule). Packet order is preserved.
- ack_i low in DATA: hold the current flit and do not pop. The same word is re-presented until a transfer.
- The next descriptor may be accepted on the edge after the TAIL transfer edge (IDLE for one cycle minimum).
- A TAIL with remaining>0 is impossible by construction. Assertions check:
  - remaining never underflows;
  - flit_type is never HEADER/TAIL while enable_o=0.
- Reset mid-packet: everything returns to reset values immediately and FIFO contents are discarded. Downstream route recovery is the node's reset responsibility.

Test Plan:
- Reset, then push words 0xA1,0xA2,0xA3 and desc dst=(2,3), len=3, with ack_i held high -> cycles: HEADER(dst 2,3), BODY A1, BODY A2, TAIL A3 on consecutive cycles; pkt_count_o=1; busy_o low after TAIL.
- desc len=0, ack_i high -> HEADER then TAIL payload 0; FIFO untouched; pkt_count_o+1.
- Hold ack_i low for 5 cycles during HDR, then again for 3 cycles on BODY A2 -> flit_o stable throughout each stall; no pop; sequence completes in order.
- desc len=4 with FIFO empty; push one word every 3 cycles -> enable_o low between words with flit_type=BODY; TAIL only on the 4th word.
- Push DEPTH+2 words with no descriptor -> wr_ready_o low after 8 words; extra words stalled, not lost. Then desc len=10 -> all 10 words emitted in order via simultaneous push/pop.
- Assert rst during BODY of a len-5 packet -> enable_o=0, busy_o=0, FIFO empty, pkt_count_o=0 immediately. A new len-1 packet then works normally.

Source files
------------

// File: rtl/noc_injector.sv
// noc_injector: local-to-mesh packet injector with its payload FIFO and shared flit types.
// Ports: clk/rst; descriptor in (desc_valid_i/desc_ready_o, desc_dst_i, desc_len_i);
//        payload in (wr_valid_i/wr_ready_o, wr_data_i); flit out (flit_o, enable_o, ack_i);
//        status (busy_o, pkt_count_o).

package noc_types;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } addr_t;

    typedef enum logic [1:0] {
        HEADER = 2'd0,
        BODY   = 2'd1,
        TAIL   = 2'd2
    } flit_type_t;

    typedef struct packed {
        addr_t      dst_addr;
        addr_t      src_addr;
        logic [7:0] vc;
        logic [7:0] rsvd;
    } flit_hdr_t;

    typedef struct packed {
        flit_type_t             flit_type;
        logic [PAYLOAD_W-1:0]   payload;
    } flit_t;
endpackage

// Generic registered FIFO, DEPTH a power of two.
// Latency: a word pushed at edge N is visible at the head from cycle N+1 (no bypass).
// Backpressure: push ignored while full, pop ignored while empty; push+pop together keeps count.
module noc_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];

    // Storage needs no reset: the empty count masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// Serialises descriptor + FIFO payload into HEADER, BODY*, TAIL flits for a mesh input port.
// Latency: header presented the cycle after descriptor accept; data flits follow at one per transfer.
// Backpressure: ack_i low holds the current flit; an empty FIFO inserts an idle (BODY, 0) bubble.
module noc_injector
    import noc_types::*;
#(
    parameter int DEPTH = 8,
    parameter int LEN_W = 4,
    localparam int PAYLOAD_W = noc_types::PAYLOAD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 desc_valid_i,
    output logic                 desc_ready_o,
    input  addr_t                desc_dst_i,
    input  logic [LEN_W-1:0]     desc_len_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [PAYLOAD_W-1:0] wr_data_i,
    output flit_t                flit_o,
    output logic                 enable_o,
    input  logic                 ack_i,
    output logic                 busy_o,
    output logic [15:0]          pkt_count_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t               state_q, state_d;
    addr_t                dst_q, dst_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [PAYLOAD_W-1:0] fifo_head;
    flit_hdr_t            hdr;

    noc_fifo #(.W(PAYLOAD_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_valid_i),
        .pop_i   (fifo_pop),
        .wdata_i (wr_data_i),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign wr_ready_o  = !fifo_full;
    assign busy_o      = (state_q != IDLE);
    assign pkt_count_o = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dst_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        desc_ready_o = 1'b0;
        enable_o     = 1'b0;
        fifo_pop     = 1'b0;
        // Idle flit must never look like HEADER/TAIL: the node frees its route on TAIL type alone.
        flit_o       = '{flit_type: BODY, payload: '0};
        hdr          = '0;
        hdr.dst_addr = dst_q;

        case (state_q)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    dst_d   = desc_dst_i;
                    rem_d   = desc_len_i;
                    state_d = HDR;
                end
            end
            HDR: begin
                enable_o = 1'b1;
                flit_o   = '{flit_type: HEADER, payload: hdr};
                if (ack_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (rem_q == '0) begin
                    // Zero-length packet: bare TAIL, FIFO untouched.
                    enable_o = 1'b1;
                    flit_o   = '{flit_type: TAIL, payload: '0};
                    if (ack_i) begin
                        state_d = IDLE;
                        cnt_d   = cnt_q + 16'd1;
                    end
                end else if (!fifo_empty) begin
                    enable_o = 1'b1;
                    flit_o   = '{flit_type: (rem_q == LEN_ONE) ? TAIL : BODY,
                                 payload: fifo_head};
                    if (ack_i) begin
                        fifo_pop = 1'b1;
                        rem_d    = rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) begin
                            state_d = IDLE;
                            cnt_d   = cnt_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    a_idle_flit: assert property (@(posedge clk) disable iff (rst)
        !enable_o |-> flit_o.flit_type == BODY);
    a_rem_underflow: assert property (@(posedge clk) disable iff (rst)
        fifo_pop |-> rem_q != '0);
`endif
endmodule

// File: tb/tb_noc_injector.sv
module tb_noc_injector;
    import noc_types::*;

    localparam int DEPTH = 8;

    typedef struct { int cyc; flit_t f; } rec_t;
    typedef struct { addr_t dst; int len; } pkt_t;

    logic        clk, rst;
    logic        desc_valid_i, desc_ready_o;
    addr_t       desc_dst_i;
    logic [3:0]  desc_len_i;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_data_i;
    flit_t       flit_o;
    logic        enable_o, ack_i, busy_o;
    logic [15:0] pkt_count_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int idle_viol = 0;
    int bubbles = 0;
    int exp_pkts = 0;
    bit rand_ack = 0;

    rec_t        got_q[$];
    flit_t       exp_q[$];
    pkt_t        pkts[$];
    logic [31:0] words[$];

    flit_t IDLE_FLIT;

    noc_injector #(.DEPTH(DEPTH), .LEN_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .desc_valid_i (desc_valid_i),
        .desc_ready_o (desc_ready_o),
        .desc_dst_i   (desc_dst_i),
        .desc_len_i   (desc_len_i),
        .wr_valid_i   (wr_valid_i),
        .wr_ready_o   (wr_ready_o),
        .wr_data_i    (wr_data_i),
        .flit_o       (flit_o),
        .enable_o     (enable_o),
        .ack_i        (ack_i),
        .busy_o       (busy_o),
        .pkt_count_o  (pkt_count_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer monitor: records what crosses the port, plus idle-rule and bubble statistics.
    always @(negedge clk) begin
        if (!rst) begin
            if (enable_o && ack_i) got_q.push_back('{cyc, flit_o});
            if (!enable_o && flit_o !== IDLE_FLIT) idle_viol++;
            if (busy_o && !enable_o) bubbles++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ack) ack_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic addr_t mk_addr(input int x, input int y);
        addr_t a;
        a.x = 4'(x);
        a.y = 4'(y);
        return a;
    endfunction

    function automatic flit_t hdr_flit(input addr_t d);
        flit_hdr_t h;
        flit_t     f;
        h = '0;
        h.dst_addr = d;
        f.flit_type = HEADER;
        f.payload = h;
        return f;
    endfunction

    // Reference: each packet is HEADER(dst), then its len words in push order, last one TAIL;
    // a zero-length packet is HEADER then TAIL with zero payload.
    function automatic void build_expected();
        int wi = 0;
        exp_q.delete();
        foreach (pkts[p]) begin
            exp_q.push_back(hdr_flit(pkts[p].dst));
            if (pkts[p].len == 0) begin
                exp_q.push_back('{flit_type: TAIL, payload: 32'h0});
            end else begin
                for (int i = 0; i < pkts[p].len; i++) begin
                    exp_q.push_back('{flit_type: (i == pkts[p].len - 1) ? TAIL : BODY,
                                      payload: words[wi]});
                    wi++;
                end
            end
            exp_pkts++;
        end
        pkts.delete();
        for (int i = 0; i < wi; i++) void'(words.pop_front());
    endfunction

    task automatic push_word(input logic [31:0] w);
        int n = 0;
        wr_valid_i = 1;
        wr_data_i  = w;
        while (!wr_ready_o && n < 2000) begin
            tick();
            n++;
        end
        if (!wr_ready_o) begin
            checks++;
            errors++;
            $display("FAIL push_timeout word %h never accepted", w);
        end else begin
            tick();
            words.push_back(w);
        end
        wr_valid_i = 0;
    endtask

    task automatic send_desc(input addr_t d, input int len);
        int n = 0;
        desc_valid_i = 1;
        desc_dst_i   = d;
        desc_len_i   = 4'(len);
        while (!desc_ready_o && n < 2000) begin
            tick();
            n++;
        end
        if (!desc_ready_o) begin
            checks++;
            errors++;
            $display("FAIL desc_timeout never ready");
        end else begin
            tick();
            acc_cyc = cyc;
            pkts.push_back('{d, len});
        end
        desc_valid_i = 0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int n = 0; n < 1000; n++) begin
            if (!busy_o) begin
                ok = 1;
                return;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL rst_enable got %b want 0", enable_o); end
        checks++; if (flit_o !== IDLE_FLIT) begin errors++; $display("FAIL rst_flit got %h want %h", flit_o, IDLE_FLIT); end
        checks++; if (desc_ready_o !== 1'b1) begin errors++; $display("FAIL rst_desc_ready got %b want 1", desc_ready_o); end
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b want 1", wr_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
        checks++; if (pkt_count_o !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", pkt_count_o); end
        repeat (3) tick();
        rst = 0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        ack_i = 1;
        push_word(32'hA1);
        push_word(32'hA2);
        push_word(32'hA3);
        send_desc(mk_addr(2, 3), 3);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL basic_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
            checks++; if (got_q[i].cyc != acc_cyc + i) begin errors++; $display("FAIL basic_cycle%0d got %0d want %0d", i, got_q[i].cyc, acc_cyc + i); end
        end
        checks++; if (pkt_count_o !== 16'(exp_pkts)) begin errors++; $display("FAIL basic_count got %0d want %0d", pkt_count_o, exp_pkts); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy_o); end
        got_q.delete();
    endtask

    task automatic test_len0();
        bit ok;
        ack_i = 1;
        push_word(32'h55);
        send_desc(mk_addr(1, 0), 0);
        wait_idle(ok);
        send_desc(mk_addr(4, 5), 1);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL len0_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL len0_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL len0_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
        end
        checks++; if (pkt_count_o !== 16'(exp_pkts)) begin errors++; $display("FAIL len0_count got %0d want %0d", pkt_count_o, exp_pkts); end
        got_q.delete();
    endtask

    task automatic test_stall();
        bit    ok;
        flit_t hf, b2;
        hf = hdr_flit(mk_addr(7, 1));
        b2 = '{flit_type: BODY, payload: 32'hB2};
        ack_i = 1;
        push_word(32'hB1);
        push_word(32'hB2);
        push_word(32'hB3);
        ack_i = 0;
        send_desc(mk_addr(7, 1), 3);
        for (int i = 0; i < 5; i++) begin
            checks++; if (flit_o !== hf || enable_o !== 1'b1) begin errors++; $display("FAIL stall_hdr%0d got %h en %b want %h en 1", i, flit_o, enable_o, hf); end
            checks++; if (desc_ready_o !== 1'b0) begin errors++; $display("FAIL stall_desc_ready%0d got %b want 0", i, desc_ready_o); end
            tick();
        end
        ack_i = 1;
        tick();
        tick();
        ack_i = 0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (flit_o !== b2 || enable_o !== 1'b1) begin errors++; $display("FAIL stall_body%0d got %h en %b want %h en 1", i, flit_o, enable_o, b2); end
            tick();
        end
        ack_i = 1;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL stall_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
        end
        got_q.delete();
    endtask

    task automatic test_bubble();
        bit ok;
        ack_i = 1;
        idle_viol = 0;
        bubbles = 0;
        send_desc(mk_addr(3, 3), 4);
        for (int k = 0; k < 4; k++) begin
            push_word(32'hC0 + 32'(k));
            tick();
            tick();
        end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bubble_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bubble_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL bubble_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
        end
        // Words arrive three edges apart, each gap leaves two empty cycles.
        checks++; if (bubbles != 6) begin errors++; $display("FAIL bubble_count got %0d want 6", bubbles); end
        checks++; if (idle_viol != 0) begin errors++; $display("FAIL bubble_idle_rule got %0d violations want 0", idle_viol); end
        got_q.delete();
    endtask

    task automatic test_fill();
        bit ok;
        ack_i = 1;
        for (int k = 0; k < DEPTH; k++) push_word(32'hD0 + 32'(k));
        checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full got wr_ready %b want 0", wr_ready_o); end
        wr_valid_i = 1;
        wr_data_i  = 32'hD8;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("FAIL fill_stalled%0d got wr_ready %b want 0", i, wr_ready_o); end
        end
        fork
            begin
                push_word(32'hD8);
                push_word(32'hD9);
            end
            send_desc(mk_addr(5, 6), DEPTH + 2);
        join
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL fill_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL fill_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
        end
        checks++; if (wr_ready_o !== 1'b1) begin errors++; $display("FAIL fill_drained got wr_ready %b want 1", wr_ready_o); end
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        bit ok;
        ack_i = 1;
        for (int k = 0; k < 5; k++) push_word(32'hE0 + 32'(k));
        send_desc(mk_addr(6, 2), 5);
        tick();
        tick();
        checks++; if (flit_o.flit_type !== BODY || enable_o !== 1'b1) begin errors++; $display("FAIL rmid_pre got %h en %b want BODY en 1", flit_o, enable_o); end
        rst = 1;
        #1;
        checks++; if (enable_o !== 1'b0) begin errors++; $display("FAIL rmid_enable got %b want 0", enable_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy_o); end
        checks++; if (pkt_count_o !== 16'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", pkt_count_o); end
        checks++; if (flit_o !== IDLE_FLIT) begin errors++; $display("FAIL rmid_flit got %h want %h", flit_o, IDLE_FLIT); end
        checks++; if (wr_ready_o !== 1'b1 || desc_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready got wr %b desc %b want 1 1", wr_ready_o, desc_ready_o); end
        tick();
        tick();
        rst = 0;
        got_q.delete();
        words.delete();
        pkts.delete();
        exp_pkts = 0;
        tick();
        push_word(32'h77);
        send_desc(mk_addr(1, 1), 1);
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rmid_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL rmid_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
        end
        checks++; if (pkt_count_o !== 16'(exp_pkts)) begin errors++; $display("FAIL rmid_count_after got %0d want %0d", pkt_count_o, exp_pkts); end
        got_q.delete();
    endtask

    task automatic test_random();
        bit   ok;
        pkt_t plan[$];
        int   total = 0;
        idle_viol = 0;
        for (int p = 0; p < 8; p++) begin
            pkt_t t;
            t.dst = mk_addr($urandom_range(0, 15), $urandom_range(0, 15));
            t.len = $urandom_range(0, 15);
            total += t.len;
            plan.push_back(t);
        end
        rand_ack = 1;
        fork
            begin
                foreach (plan[p]) send_desc(plan[p].dst, plan[p].len);
            end
            begin
                for (int k = 0; k < total; k++) begin
                    push_word($urandom);
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        join
        wait_idle(ok);
        rand_ack = 0;
        tick();
        ack_i = 1;
        checks++; if (!ok) begin errors++; $display("FAIL rand_idle busy stuck high"); end
        build_expected();
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++; if (got_q[i].f !== exp_q[i]) begin errors++; $display("FAIL rand_flit%0d got %h want %h", i, got_q[i].f, exp_q[i]); end
        end
        checks++; if (pkt_count_o !== 16'(exp_pkts)) begin errors++; $display("FAIL rand_count got %0d want %0d", pkt_count_o, exp_pkts); end
        checks++; if (idle_viol != 0) begin errors++; $display("FAIL rand_idle_rule got %0d violations want 0", idle_viol); end
        got_q.delete();
    endtask

    initial begin
        IDLE_FLIT    = '{flit_type: BODY, payload: 32'h0};
        rst          = 1;
        desc_valid_i = 0;
        desc_dst_i   = '0;
        desc_len_i   = '0;
        wr_valid_i   = 0;
        wr_data_i    = '0;
        ack_i        = 0;
        test_reset();
        test_basic();
        test_len0();
        test_stall();
        test_bubble();
        test_fill();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
